// File: rtl/ubi_stream_decoder_pkg.sv
// Shared types and derived constants for the windowed bipolar decoder.
// Window length and saturation limits are functions of BITWIDTH.
package ubi_stream_decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Window length N = 2^bw enabled bits
    function automatic int winLen(input int bw);
        return 1 << bw;
    endfunction

    // Bipolar zero point 2^(bw-1)
    function automatic int halfOf(input int bw);
        return 1 << (bw - 1);
    endfunction

    function automatic int satMax(input int bw);
        return (1 << (bw - 1)) - 1;
    endfunction

    function automatic int satMin(input int bw);
        return -(1 << (bw - 1));
    endfunction

endpackage

// File: rtl/ubi_stream_decoder_ones_counter.sv
// Per-lane ones counter with bipolar subtract-and-saturate output.
// oDec reflects the count including the bit sampled this cycle.
module ubi_ones_counter
    import ubi_stream_decoder_pkg::*;
#(
    parameter int BITWIDTH = 8
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iClr,
    input  logic              iInc,
    input  logic              iDone,
    output logic [BITWIDTH:0] oVal,
    output logic [BITWIDTH-1:0] oDec
);

    localparam logic [BITWIDTH:0] FULL =
        (BITWIDTH + 1)'(winLen(BITWIDTH));
    localparam logic [BITWIDTH-1:0] HALF =
        BITWIDTH'(halfOf(BITWIDTH));
    localparam logic [BITWIDTH-1:0] SMAX =
        BITWIDTH'(satMax(BITWIDTH));

    logic [BITWIDTH:0]   finalCnt;
    logic [BITWIDTH-1:0] diff;

    // Final count folds in the current bit so the last sample is decoded
    always_comb begin
        finalCnt = oVal + {{BITWIDTH{1'b0}}, iInc};
        diff     = finalCnt[BITWIDTH-1:0] - HALF;
        oDec     = (finalCnt == FULL) ? SMAX : diff;
    end

    // Count enabled ones; window end or clear restarts from zero
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oVal <= '0;
        end else if (iClr || iDone) begin
            oVal <= '0;
        end else if (iInc) begin
            oVal <= oVal + 1'b1;
        end
    end

endmodule

// File: rtl/ubi_stream_decoder.sv
// Windowed bipolar unary-to-binary decoder over LANES streams.
// Shared window counter and FSM; one ones counter per lane.
module ubi_stream_decoder
    import ubi_stream_decoder_pkg::*;
#(
    parameter int BITWIDTH   = 8,
    parameter int LANES      = 4,
    parameter int CONTINUOUS = 0
) (
    input  logic                      iClk,
    input  logic                      iRstN,
    input  logic                      iClr,
    input  logic                      iStart,
    input  logic                      iEn,
    input  logic [LANES-1:0]          iBits,
    output logic [LANES*BITWIDTH-1:0] oVal,
    output logic                      oValid,
    output logic                      oBusy
);

    localparam logic [BITWIDTH:0] LAST =
        (BITWIDTH + 1)'(winLen(BITWIDTH) - 1);

    state_e                    state;
    logic [BITWIDTH:0]         winCnt;
    logic                      open;
    logic                      sample;
    logic                      lastBit;
    logic [LANES*BITWIDTH-1:0] decAll;
    logic [BITWIDTH:0]         unusedLaneCnt [LANES];

    // The iStart cycle is already slot 0 of the window
    always_comb begin
        open    = (state == RUN) || iStart;
        sample  = open && iEn && !iClr;
        lastBit = sample && (winCnt == LAST);
    end

    // Window position; the Nth enabled bit closes the window
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            winCnt <= '0;
        end else if (iClr || lastBit) begin
            winCnt <= '0;
        end else if (sample) begin
            winCnt <= winCnt + 1'b1;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : gLane
        ubi_ones_counter #(
            .BITWIDTH(BITWIDTH)
        ) uCnt (
            .iClk  (iClk),
            .iRstN (iRstN),
            .iClr  (iClr),
            .iInc  (sample && iBits[k]),
            .iDone (lastBit),
            .oVal  (unusedLaneCnt[k]),
            .oDec  (decAll[k*BITWIDTH +: BITWIDTH])
        );
    end

    // Control FSM; results latched as a whole at window end
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state  <= IDLE;
            oBusy  <= 1'b0;
            oValid <= 1'b0;
            oVal   <= '0;
        end else begin
            oValid <= 1'b0;
            if (iClr) begin
                state <= IDLE;
                oBusy <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (iStart) begin
                            state <= RUN;
                            oBusy <= 1'b1;
                        end
                    end
                    RUN: begin
                    end
                endcase
                if (lastBit) begin
                    oVal   <= decAll;
                    oValid <= 1'b1;
                    if (CONTINUOUS == 0) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/ubi_stream_decoder.md
Name: ubi_stream_decoder

Overview:
- Windowed bipolar unary-to-binary decoder: the read-back end of the unary butterfly datapath.
- Counts ones on LANES parallel bipolar bitstreams over a window of 2^BITWIDTH enabled cycles. Converts each count to a saturated two's-complement BITWIDTH-bit value.
- Sits after the butterfly outputs (real0, img0, real1, img1) so results return to the binary domain for checking and downstream use.

Parameters:
- BITWIDTH, 8, output width; window length N = 2^BITWIDTH enabled bits
- LANES, 4, number of parallel bitstreams decoded over one shared window
- CONTINUOUS, 0, 1 = start the next window automatically after each completed window; 0 = return to IDLE

Ports:
- iClk  input  1  clock, all state on rising edge
- iRstN  input  1  asynchronous active-low reset
- iClr  input  1  synchronous clear; aborts the window and returns to IDLE
- iStart  input  1  single-cycle pulse that opens a window (honoured in IDLE only)
- iEn  input  1  bit-valid qualifier; counts and window advance only when high
- iBits  input  LANES  one bipolar stream bit per lane
- oVal  output  LANES*BITWIDTH  lane k in bits [k*BITWIDTH +: BITWIDTH], two's complement
- oValid  output  1  one-cycle pulse when oVal updates
- oBusy  output  1  high while a window is open (state RUN)

Behaviour:
- Reset (iRstN=0, async): state IDLE, window counter 0, all lane counters 0, oVal 0, oValid 0, oBusy 0. Reset mid-window discards the partial window and produces no oValid.
- States:
  - IDLE: iStart=1 -> RUN. The iStart cycle is itself the first sample slot: if iEn=1 in that cycle, bit 0 is counted.
  - RUN: each cycle with iEn=1, the window counter increments and lane k's counter increments if iBits[k]=1.
  - iEn=0: nothing changes (stall). Stalls of any length are allowed.
- Window end: the cycle in which the Nth enabled bit is sampled.
  - Next edge: oVal latched from the final counts (including that Nth bit), oValid=1 for exactly one cycle, counters cleared.
  - State becomes IDLE if CONTINUOUS=0, otherwise stays RUN.
  - With CONTINUOUS=1, the cycle after the Nth bit is already slot 0 of the next window, so there is no bubble.
- oBusy = (state==RUN), registered. With CONTINUOUS=0 it falls on the same edge that raises oValid.
- iStart in RUN is ignored. iStart with iClr in the same cycle: iClr wins and the state stays IDLE.
- iClr=1: next edge gives IDLE, counters 0, oValid 0. oVal holds its last decoded value.
- Arithmetic:
  - Lane counter width is BITWIDTH+1, range 0..N.
  - Decoded value = ones − 2^(BITWIDTH−1), i.e. bipolar x·2^(BITWIDTH−1) with x = 2·ones/N − 1.
  - Saturate to [−2^(BITWIDTH−1), 2^(BITWIDTH−1)−1]. Only ones=N saturates, and it maps to 2^(BITWIDTH−1)−1.
- Window counter width is BITWIDTH+1. Compare to N; no wrap-around is permitted inside a window.
- oVal holds between oValid pulses and is never partially updated.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, RUN)
  - helper constants WIN_LEN = 2^BITWIDTH and HALF = 2^(BITWIDTH−1), derived from BITWIDTH
  - saturation max and min constants
- One sub-module per lane: ubi_ones_counter.
  - Inputs: iClk, iRstN, iClr (local clear), iInc, iDone.
  - Output: oVal, the BITWIDTH+1-bit count, cleared on iDone.
  - Contains the subtract-and-saturate stage.
- The top level instantiates LANES counters, the shared window counter and the FSM.

Test Plan (BITWIDTH=4, N=16, LANES=4, CONTINUOUS=0 unless noted):
- Reset, iStart, iEn=1 for 16 cycles with lane0 all 1s, lane1 all 0s, lane2 alternating 1/0, lane3 twelve 1s then four 0s -> one oValid pulse on the edge after cycle 16; oVal lanes = 0x7 (saturated), 0x8 (−8), 0x0, 0x4; oBusy falls on the same edge.
- Same stimulus as the first test with iEn=0 inserted for 5 random cycles -> identical oVal values, oValid delayed by exactly 5 cycles, counts unchanged during stalls.
- iClr asserted after 9 enabled bits -> IDLE next cycle, no oValid, oVal keeps its previous value; a fresh 16-bit window of all 1s then decodes lane0 = 0x7.
- iRstN pulled low mid-window (after 7 bits) -> oVal=0, oBusy=0, oValid=0 immediately; no oValid is produced until a new iStart and 16 enabled bits.
- CONTINUOUS=1: one iStart, then 48 continuous enabled bits forming three windows (all 1s / all 0s / 8 ones) -> three oValid pulses exactly 16 cycles apart; lane0 = 0x7, 0x8, 0x0; oBusy stays high throughout.
- iStart pulsed again during RUN, and iStart together with iClr in IDLE -> both ignored; the window length stays 16 and no extra oValid is produced.
